mult_secuencial: RTL and testbench
==================================

MULT_SECUENCIAL -- requirements
Module: mult_secuencial

Interface
REQ-001 SHALL take N, default 16, from shared header constantes.h: total operand width, in bits.
REQ-002 SHALL take M, default 7, from constantes.h: integer bits, with N = 1+M+F.
REQ-003 SHALL take F, default 8, from constantes.h: fraction bits.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset_n  input  1  reset, asynchronous, active-low.
REQ-006 start  input  1  request to multiply; sampled only when not busy.
REQ-007 a  input  N signed  multiplicand, Q(M).(F).
REQ-008 b  input  N signed  multiplier, Q(M).(F).
REQ-009 busy  output  1  high while a multiplication is in progress.
REQ-010 done  output  1  one-cycle pulse; producto valid.
REQ-011 producto  output  2N signed  full product, Q(2M+1).(2F), fed unmodified to the downstream saturation/truncation stage.

Function
REQ-012 SHALL compute the exact signed product a*b using radix-2 Booth shift-add, one step per clock.
REQ-013 SHALL implement FSM states IDLE, BUSY, DONE.
REQ-014 IDLE: start=1 at an edge SHALL latch a and b, clear the accumulator, load the step counter with N, and move to BUSY.
REQ-015 IDLE: start=0 SHALL hold all state.
REQ-016 BUSY: each edge SHALL perform one Booth step (add, subtract or no-op on the pair {b bit i, b bit i-1}, then arithmetic shift right), then decrement the counter.
REQ-017 BUSY SHALL transition to DONE on the edge that completes step N.
REQ-018 DONE: the state SHALL last exactly one cycle, with done=1, then return to IDLE.
REQ-019 DONE: start=1 SHALL be accepted exactly as in IDLE, giving back-to-back operation.
REQ-020 Latency: start accepted at edge k SHALL give done=1 during the cycle after edge k+N, so the throughput is one result per N+1 cycles.
REQ-021 busy SHALL be 1 only in BUSY.
REQ-022 done SHALL be 1 only in DONE.
REQ-023 producto SHALL update only on entry to DONE.
REQ-024 producto SHALL hold its value until the next result replaces it.
REQ-025 start while busy=1 SHALL be ignored: no queuing and no operand change.
REQ-026 a and b changing after acceptance SHALL NOT affect the result.
REQ-027 The accumulator SHALL be N+1 bits wide internally, so that a = -2^(N-1) does not overflow on subtract.
REQ-028 (-2^(N-1)) * (-2^(N-1)) SHALL yield +2^(2N-2) exactly, with no saturation in this block.
REQ-029 The counter SHALL be ceil(log2(N+1)) bits wide and SHALL NOT wrap.

Reset
REQ-030 reset_n=0 SHALL force, asynchronously, state=IDLE, busy=0, done=0, producto=0, accumulator=0 and counter=0.
REQ-031 Reset during BUSY SHALL abort the operation: no done pulse, producto=0.
REQ-032 After reset_n rises, the first start accepted SHALL behave as in REQ-014.

Structure
REQ-033 N, M and F SHALL come only from constantes.h.
REQ-034 FSM state encodings SHALL be local to the module.
REQ-035 No sub-module is required; the Booth add/sub/shift step MAY be split into sub-module paso_booth.
REQ-036 Saturation and truncation SHALL NOT be done here; the parent SHALL connect producto to the existing truncation stage.

Verification (N=16)
REQ-037 a=3, b=5, start pulse -> busy for 16 cycles, then done pulse with producto=0x0000000F.
REQ-038 a=0xFFFF (-1), b=0x0001 -> producto=0xFFFFFFFF; a=0x0100 (1.0), b=0x0180 (1.5) -> producto=0x00018000.
REQ-039 a=b=0x8000 -> producto=0x40000000; a=0x8000, b=0x7FFF -> producto=0xC0008000.
REQ-040 start re-asserted with new operands at busy cycle 5 -> ignored; result equals the first operands; exactly one done pulse.
REQ-041 reset_n low at busy cycle 8 -> busy=0, done=0 and producto=0 immediately; no done pulse follows; the next start gives a correct result.
REQ-042 start held high continuously with operands changing per accept -> done every 17 cycles, each result correct.

Source files
------------

// File: rtl/mult_secuencial_pkg.sv
// Shared word-format constants and Booth step types
// for the sequential fixed-point multiplier.
package mult_secuencial_pkg;

  localparam int M  = 7;
  localparam int F  = 8;
  localparam int N  = 1 + M + F;
  localparam int CW = $clog2(N + 1);

  // One extra accumulator bit keeps a = -2^(N-1) from overflowing on subtract
  typedef struct packed {
    logic [N:0]   acc;
    logic [N-1:0] q;
    logic         q_1;
  } booth_t;

  function automatic logic [2*N-1:0] booth_prod(
    input booth_t s
  );
    return {s.acc[N-1:0], s.q};
  endfunction

endpackage

// File: rtl/mult_secuencial_paso_booth.sv
// One radix-2 Booth step: add/sub/no-op on {q[0], q_1},
// then arithmetic shift right of {acc, q, q_1}.
module mult_secuencial_paso_booth
  import mult_secuencial_pkg::*;
(
  input  logic [N-1:0] m,
  input  booth_t       cur,
  output booth_t       nxt
);

  logic [N:0] mx;
  logic [N:0] sum;

  assign mx = {m[N-1], m};

  always_comb begin
    sum = cur.acc;
    case ({cur.q[0], cur.q_1})
      2'b01:   sum = cur.acc + mx;
      2'b10:   sum = cur.acc - mx;
      default: sum = cur.acc;
    endcase
    nxt.acc = {sum[N], sum[N:1]};
    nxt.q   = {sum[0], cur.q[N-1:1]};
    nxt.q_1 = cur.q[0];
  end

endmodule

// File: rtl/mult_secuencial.sv
// Sequential signed Q(M).(F) multiplier, one Booth step
// per clock; full 2N-bit product, no saturation.
module mult_secuencial
  import mult_secuencial_pkg::*;
(
  input  logic           clk,
  input  logic           reset_n,
  input  logic           start,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic           busy,
  output logic           done,
  output logic [2*N-1:0] producto
);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t        state;
  state_t        state_nxt;
  booth_t        cur;
  booth_t        nxt;
  logic [N-1:0]  m;
  logic [CW-1:0] cnt;
  logic          accept;
  logic          last;

  assign accept = start && (state != BUSY);
  assign last   = (cnt == CW'(1));

  mult_secuencial_paso_booth u_paso (
    .m   (m),
    .cur (cur),
    .nxt (nxt)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = BUSY;
      BUSY:    if (last)  state_nxt = DONE;
      DONE:    state_nxt = start ? BUSY : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    unique case (state)
      BUSY:    busy = 1'b1;
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cur      <= '0;
      m        <= '0;
      cnt      <= '0;
      producto <= '0;
    end else if (accept) begin
      cur <= '{acc: '0, q: b, q_1: 1'b0};
      m   <= a;
      cnt <= CW'(N);
    end else if (state == BUSY && cnt != '0) begin
      cur <= nxt;
      cnt <= cnt - CW'(1);
      if (last) producto <= booth_prod(nxt);
    end
  end

endmodule

// File: tb/tb_mult_secuencial.sv
// Scoreboard bench for mult_secuencial: directed
// vectors, busy-start, mid-run reset, back-to-back.
module tb_mult_secuencial;
  import mult_secuencial_pkg::*;

  logic           clk = 1'b0;
  logic           reset_n;
  logic           start;
  logic [N-1:0]   a;
  logic [N-1:0]   b;
  logic           busy;
  logic           done;
  logic [2*N-1:0] producto;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int last_done = 0;
  int ndone = 0;
  bit b2b = 0;
  bit gap_arm = 0;
  logic [2*N-1:0] sb[$];

  always #5 clk = ~clk;

  mult_secuencial dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (start),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .producto (producto)
  );

  task automatic chk(
    input string name,
    input logic [63:0] act,
    input logic [63:0] exp
  );
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h",
               name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    cyc++;
    if (reset_n === 1'b1 && done === 1'b1) begin
      ndone++;
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL spurious_done: got %0h want none",
                 producto);
      end else begin
        chk("producto", producto, sb.pop_front());
      end
      if (b2b) begin
        if (gap_arm) chk("done_gap", cyc - last_done, 17);
        gap_arm = 1;
      end
      last_done = cyc;
    end
  end

  task automatic drain();
    int k = 0;
    while (sb.size() != 0 && k < 60) begin
      @(negedge clk);
      k++;
    end
    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain_timeout: got %0d pending want 0",
               sb.size());
      sb.delete();
    end
  endtask

  task automatic op(
    input logic [N-1:0]   ia,
    input logic [N-1:0]   ib,
    input logic [2*N-1:0] exp
  );
    int n = 0;
    int nb = 0;
    @(negedge clk);
    a = ia;
    b = ib;
    start = 1'b1;
    @(posedge clk);
    sb.push_back(exp);
    #1;
    start = 1'b0;
    a = ~ia;
    b = ib ^ 16'h5a5a;
    do begin
      @(negedge clk);
      n++;
      if (busy) nb++;
    end while (!done && n < 40);
    chk("latency", n, 17);
    chk("busy_cycles", nb, 16);
    @(negedge clk);
    drain();
  endtask

  typedef struct {
    logic [N-1:0]   x;
    logic [N-1:0]   y;
    logic [2*N-1:0] p;
  } vec_t;

  vec_t dv[$];
  vec_t bv[$];

  initial begin
    int n0;
    dv = '{
      '{16'h0003, 16'h0005, 32'h0000000F},
      '{16'hFFFF, 16'h0001, 32'hFFFFFFFF},
      '{16'h0100, 16'h0180, 32'h00018000},
      '{16'h8000, 16'h8000, 32'h40000000},
      '{16'h8000, 16'h7FFF, 32'hC0008000},
      '{16'h7FFF, 16'h7FFF, 32'h3FFF0001},
      '{16'h0000, 16'h1234, 32'h00000000}
    };
    bv = '{
      '{16'h0005, 16'hFFFD, 32'hFFFFFFF1},
      '{16'h7FFF, 16'h8000, 32'hC0008000},
      '{16'h1234, 16'h0010, 32'h00012340},
      '{16'hFFFF, 16'hFFFF, 32'h00000001}
    };

    reset_n = 1'b0;
    start = 1'b0;
    a = '0;
    b = '0;
    #2;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_producto", producto, 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    foreach (dv[i]) op(dv[i].x, dv[i].y, dv[i].p);

    // start asserted during busy cycle 5 must be ignored
    @(negedge clk);
    a = 16'h0200;
    b = 16'h0300;
    start = 1'b1;
    @(posedge clk);
    sb.push_back(32'h00060000);
    n0 = ndone;
    #1;
    start = 1'b0;
    repeat (4) @(negedge clk);
    @(negedge clk);
    a = 16'h1111;
    b = 16'h2222;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (40) @(negedge clk);
    chk("ignore_one_done", ndone - n0, 1);
    chk("ignore_sb_empty", sb.size(), 0);

    // reset in busy cycle 8 aborts the run
    @(negedge clk);
    a = 16'h0300;
    b = 16'h0200;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (8) @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_producto", producto, 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    n0 = ndone;
    repeat (25) @(negedge clk);
    chk("abort_no_done", ndone - n0, 0);
    op(16'h0100, 16'hFE00, 32'hFFFE0000);

    // start held high, operands changed per accept
    b2b = 1;
    gap_arm = 0;
    n0 = ndone;
    foreach (bv[i]) begin
      @(negedge clk);
      a = bv[i].x;
      b = bv[i].y;
      start = 1'b1;
      @(posedge clk);
      sb.push_back(bv[i].p);
      #1;
      a = 16'hDEAD;
      b = 16'hBEEF;
      if (i == bv.size() - 1) start = 1'b0;
      else repeat (16) @(posedge clk);
    end
    drain();
    repeat (3) @(negedge clk);
    b2b = 0;
    chk("b2b_count", ndone - n0, 4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
